// File: rtl/hazard_forward_unit.sv
// Hazard detection, forwarding selects and memory freeze control for the 5-stage MIPS pipeline.
// Also keeps saturating stall / forward statistics.
module hazard_forward_unit #(
    parameter int unsigned REG_BITS    = 5,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned FORWARDING  = 1,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [REG_BITS-1:0]  id_rs_i,
    input  logic [REG_BITS-1:0]  id_rt_i,
    input  logic                 id_use_rs_i,
    input  logic                 id_use_rt_i,
    input  logic                 id_branch_i,
    input  logic [REG_BITS-1:0]  ex_rs_i,
    input  logic [REG_BITS-1:0]  ex_rt_i,
    input  logic                 ex_reg_write_i,
    input  logic                 ex_mem_read_i,
    input  logic [REG_BITS-1:0]  ex_dest_i,
    input  logic                 mem_reg_write_i,
    input  logic                 mem_mem_read_i,
    input  logic                 mem_mem_write_i,
    input  logic [REG_BITS-1:0]  mem_dest_i,
    input  logic                 wb_reg_write_i,
    input  logic [REG_BITS-1:0]  wb_dest_i,
    output logic                 hazard_o,
    output logic                 freeze_o,
    output logic [1:0]           forwarding_mux0_ex_o,
    output logic [1:0]           forwarding_mux1_ex_o,
    output logic                 forward_id_rs_o,
    output logic                 forward_id_rt_o,
    output logic [CNT_WIDTH-1:0] stall_count_o,
    output logic [CNT_WIDTH-1:0] forward_count_o
);

    localparam bit          FwdEn       = FORWARDING != 0;
    localparam bit          LongMem     = MEM_LATENCY > 1;
    localparam int unsigned WaitInitInt = LongMem ? MEM_LATENCY - 2 : 0;
    localparam logic [3:0]  WaitInit    = 4'(WaitInitInt);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] fwd_cnt_q, fwd_cnt_d;

    logic rs_valid, rt_valid;
    logic rs_hit_ex, rs_hit_mem, rt_hit_ex, rt_hit_mem;
    logic hazard_raw, freeze_raw, mem_access, mem_alu_valid, fwd_any;
    logic fwd_id_rs_raw, fwd_id_rt_raw;

    // MEM result is only forwardable when it is an ALU value, not a pending load.
    function automatic logic [1:0] ex_fwd_sel(input logic [REG_BITS-1:0] op,
                                              input logic                mem_ok,
                                              input logic [REG_BITS-1:0] mem_dest,
                                              input logic                wb_we,
                                              input logic [REG_BITS-1:0] wb_dest);
        logic [1:0] sel;
        sel = 2'd0;
        if (op != '0) begin
            if (mem_ok && mem_dest == op) begin
                sel = 2'd2;
            end else if (wb_we && wb_dest == op) begin
                sel = 2'd1;
            end
        end
        return sel;
    endfunction

    assign rs_valid      = id_use_rs_i & (id_rs_i != '0);
    assign rt_valid      = id_use_rt_i & (id_rt_i != '0);
    assign rs_hit_ex     = ex_reg_write_i & (ex_dest_i == id_rs_i);
    assign rt_hit_ex     = ex_reg_write_i & (ex_dest_i == id_rt_i);
    assign rs_hit_mem    = mem_reg_write_i & (mem_dest_i == id_rs_i);
    assign rt_hit_mem    = mem_reg_write_i & (mem_dest_i == id_rt_i);
    assign mem_access    = mem_mem_read_i | mem_mem_write_i;
    assign mem_alu_valid = mem_reg_write_i & ~mem_mem_read_i;

    always_comb begin
        if (FwdEn) begin
            hazard_raw =
                (rs_valid & ((rs_hit_ex & (ex_mem_read_i | id_branch_i)) |
                             (rs_hit_mem & mem_mem_read_i & id_branch_i))) |
                (rt_valid & ((rt_hit_ex & (ex_mem_read_i | id_branch_i)) |
                             (rt_hit_mem & mem_mem_read_i & id_branch_i)));
        end else begin
            hazard_raw = (rs_valid & (rs_hit_ex | rs_hit_mem)) |
                         (rt_valid & (rt_hit_ex | rt_hit_mem));
        end
    end

    always_comb begin
        forwarding_mux0_ex_o = 2'd0;
        forwarding_mux1_ex_o = 2'd0;
        if (FwdEn) begin
            forwarding_mux0_ex_o = ex_fwd_sel(ex_rs_i, mem_alu_valid, mem_dest_i,
                                              wb_reg_write_i, wb_dest_i);
            forwarding_mux1_ex_o = ex_fwd_sel(ex_rt_i, mem_alu_valid, mem_dest_i,
                                              wb_reg_write_i, wb_dest_i);
        end
    end

    assign fwd_id_rs_raw = FwdEn & id_branch_i & mem_alu_valid &
                           (mem_dest_i == id_rs_i) & (id_rs_i != '0);
    assign fwd_id_rt_raw = FwdEn & id_branch_i & mem_alu_valid &
                           (mem_dest_i == id_rt_i) & (id_rt_i != '0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (mem_access && LongMem) begin
                    state_d = StWait;
                    cnt_d   = WaitInit;
                end
            end
            StWait: begin
                // Release cycle: the held op leaves MEM without re-triggering.
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        freeze_raw = 1'b0;
        unique case (state_q)
            StIdle:  freeze_raw = mem_access & LongMem;
            StWait:  freeze_raw = cnt_q != 4'd0;
            default: freeze_raw = 1'b0;
        endcase
    end

    assign freeze_o        = freeze_raw & ~reset_i;
    assign hazard_o        = hazard_raw & ~freeze_raw & ~reset_i;
    assign forward_id_rs_o = fwd_id_rs_raw & ~reset_i;
    assign forward_id_rt_o = fwd_id_rt_raw & ~reset_i;

    assign fwd_any = (forwarding_mux0_ex_o != 2'd0) | (forwarding_mux1_ex_o != 2'd0) |
                     forward_id_rs_o | forward_id_rt_o;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if ((hazard_o | freeze_o) && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
        if (!freeze_o && fwd_any && fwd_cnt_q != '1) begin
            fwd_cnt_d = fwd_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_count_o   = stall_cnt_q;
    assign forward_count_o = fwd_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench: three configurations share one stimulus stream, checked against a
// cycle-level reference model of the hazard/forward/freeze rules.
module tb_hazard_forward_unit;

    typedef struct packed {
        logic       reset;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_use_rs;
        logic       id_use_rt;
        logic       id_branch;
        logic [4:0] ex_rs;
        logic [4:0] ex_rt;
        logic       ex_reg_write;
        logic       ex_mem_read;
        logic [4:0] ex_dest;
        logic       mem_reg_write;
        logic       mem_mem_read;
        logic       mem_mem_write;
        logic [4:0] mem_dest;
        logic       wb_reg_write;
        logic [4:0] wb_dest;
    } stim_t;

    typedef struct packed {
        logic        hazard;
        logic        freeze;
        logic [1:0]  m0;
        logic [1:0]  m1;
        logic        fr;
        logic        ft;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rs = '0, ex_rt = '0;
    logic [4:0] ex_dest = '0, mem_dest = '0, wb_dest = '0;
    logic       id_use_rs = 0, id_use_rt = 0, id_branch = 0;
    logic       ex_reg_write = 0, ex_mem_read = 0;
    logic       mem_reg_write = 0, mem_mem_read = 0, mem_mem_write = 0, wb_reg_write = 0;

    logic        hz[3], fz[3], fr[3], ft[3];
    logic [1:0]  m0[3], m1[3];
    logic [31:0] sc0, fc0, sc1, fc1;
    logic [3:0]  sc2, fc2;

    int n_asserts = 0;
    int n_fail    = 0;

    exp_t q0[$], q1[$], q2[$];

    // Reference model state per instance
    int     frz_left[3];
    bit     in_rel[3];
    longint stall_c[3], fwd_c[3];

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_BITS(5), .MEM_LATENCY(1), .FORWARDING(1), .CNT_WIDTH(32)) u_dut0 (
        .clk_i(clk), .reset_i(reset), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt), .id_branch_i(id_branch),
        .ex_rs_i(ex_rs), .ex_rt_i(ex_rt), .ex_reg_write_i(ex_reg_write),
        .ex_mem_read_i(ex_mem_read), .ex_dest_i(ex_dest), .mem_reg_write_i(mem_reg_write),
        .mem_mem_read_i(mem_mem_read), .mem_mem_write_i(mem_mem_write), .mem_dest_i(mem_dest),
        .wb_reg_write_i(wb_reg_write), .wb_dest_i(wb_dest), .hazard_o(hz[0]), .freeze_o(fz[0]),
        .forwarding_mux0_ex_o(m0[0]), .forwarding_mux1_ex_o(m1[0]),
        .forward_id_rs_o(fr[0]), .forward_id_rt_o(ft[0]),
        .stall_count_o(sc0), .forward_count_o(fc0));

    hazard_forward_unit #(.REG_BITS(5), .MEM_LATENCY(4), .FORWARDING(1), .CNT_WIDTH(32)) u_dut1 (
        .clk_i(clk), .reset_i(reset), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt), .id_branch_i(id_branch),
        .ex_rs_i(ex_rs), .ex_rt_i(ex_rt), .ex_reg_write_i(ex_reg_write),
        .ex_mem_read_i(ex_mem_read), .ex_dest_i(ex_dest), .mem_reg_write_i(mem_reg_write),
        .mem_mem_read_i(mem_mem_read), .mem_mem_write_i(mem_mem_write), .mem_dest_i(mem_dest),
        .wb_reg_write_i(wb_reg_write), .wb_dest_i(wb_dest), .hazard_o(hz[1]), .freeze_o(fz[1]),
        .forwarding_mux0_ex_o(m0[1]), .forwarding_mux1_ex_o(m1[1]),
        .forward_id_rs_o(fr[1]), .forward_id_rt_o(ft[1]),
        .stall_count_o(sc1), .forward_count_o(fc1));

    hazard_forward_unit #(.REG_BITS(5), .MEM_LATENCY(8), .FORWARDING(0), .CNT_WIDTH(4)) u_dut2 (
        .clk_i(clk), .reset_i(reset), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt), .id_branch_i(id_branch),
        .ex_rs_i(ex_rs), .ex_rt_i(ex_rt), .ex_reg_write_i(ex_reg_write),
        .ex_mem_read_i(ex_mem_read), .ex_dest_i(ex_dest), .mem_reg_write_i(mem_reg_write),
        .mem_mem_read_i(mem_mem_read), .mem_mem_write_i(mem_mem_write), .mem_dest_i(mem_dest),
        .wb_reg_write_i(wb_reg_write), .wb_dest_i(wb_dest), .hazard_o(hz[2]), .freeze_o(fz[2]),
        .forwarding_mux0_ex_o(m0[2]), .forwarding_mux1_ex_o(m1[2]),
        .forward_id_rs_o(fr[2]), .forward_id_rt_o(ft[2]),
        .stall_count_o(sc2), .forward_count_o(fc2));

    function automatic logic [1:0] ref_ex_sel(input bit fwd, input logic [4:0] op,
                                              input stim_t s);
        if (!fwd || op == 0) return 2'd0;
        if (s.mem_reg_write && !s.mem_mem_read && s.mem_dest == op) return 2'd2;
        if (s.wb_reg_write && s.wb_dest == op) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [31:0] sat(input longint c, input int cw);
        longint cap;
        cap = (longint'(1) << cw) - 1;
        return 32'(c > cap ? cap : c);
    endfunction

    task automatic model_step(input int k, input int lat, input bit fwd, input int cw,
                              input stim_t s, output exp_t e);
        bit vs, vt, rs_ex, rs_mem, rt_ex, rt_mem, haz, frz, fri, fti;
        logic [1:0] s0, s1;
        vs     = s.id_use_rs && s.id_rs != 0;
        vt     = s.id_use_rt && s.id_rt != 0;
        rs_ex  = s.ex_reg_write && s.ex_dest == s.id_rs;
        rt_ex  = s.ex_reg_write && s.ex_dest == s.id_rt;
        rs_mem = s.mem_reg_write && s.mem_dest == s.id_rs;
        rt_mem = s.mem_reg_write && s.mem_dest == s.id_rt;
        if (fwd)
            haz = (vs && ((rs_ex && (s.ex_mem_read || s.id_branch)) ||
                          (rs_mem && s.mem_mem_read && s.id_branch))) ||
                  (vt && ((rt_ex && (s.ex_mem_read || s.id_branch)) ||
                          (rt_mem && s.mem_mem_read && s.id_branch)));
        else
            haz = (vs && (rs_ex || rs_mem)) || (vt && (rt_ex || rt_mem));
        s0  = ref_ex_sel(fwd, s.ex_rs, s);
        s1  = ref_ex_sel(fwd, s.ex_rt, s);
        fri = fwd && s.id_branch && s.mem_reg_write && !s.mem_mem_read &&
              s.mem_dest == s.id_rs && s.id_rs != 0;
        fti = fwd && s.id_branch && s.mem_reg_write && !s.mem_mem_read &&
              s.mem_dest == s.id_rt && s.id_rt != 0;
        frz = 0;
        if (s.reset) begin
            frz_left[k] = 0;
            in_rel[k]   = 0;
            haz = 0;
            fri = 0;
            fti = 0;
        end else if (frz_left[k] > 0) begin
            frz = 1;
            frz_left[k]--;
            if (frz_left[k] == 0) in_rel[k] = 1;
        end else if (in_rel[k]) begin
            in_rel[k] = 0;
        end else if ((s.mem_mem_read || s.mem_mem_write) && lat > 1) begin
            frz = 1;
            frz_left[k] = lat - 2;
            in_rel[k]   = (lat == 2);
        end
        if (frz) haz = 0;
        e = '{hazard: haz, freeze: frz, m0: s0, m1: s1, fr: fri, ft: fti,
              sc: sat(stall_c[k], cw), fc: sat(fwd_c[k], cw)};
        if (s.reset) begin
            stall_c[k] = 0;
            fwd_c[k]   = 0;
        end else begin
            if (haz || frz) stall_c[k]++;
            if (!frz && (s0 != 0 || s1 != 0 || fri || fti)) fwd_c[k]++;
        end
    endtask

    task automatic cycle(input stim_t s, input bit push);
        exp_t e0, e1, e2;
        @(posedge clk);
        #1;
        reset = s.reset;           id_rs = s.id_rs;               id_rt = s.id_rt;
        id_use_rs = s.id_use_rs;   id_use_rt = s.id_use_rt;       id_branch = s.id_branch;
        ex_rs = s.ex_rs;           ex_rt = s.ex_rt;               ex_reg_write = s.ex_reg_write;
        ex_mem_read = s.ex_mem_read;   ex_dest = s.ex_dest;
        mem_reg_write = s.mem_reg_write; mem_mem_read = s.mem_mem_read;
        mem_mem_write = s.mem_mem_write; mem_dest = s.mem_dest;
        wb_reg_write = s.wb_reg_write;   wb_dest = s.wb_dest;
        model_step(0, 1, 1'b1, 32, s, e0);
        model_step(1, 4, 1'b1, 32, s, e1);
        model_step(2, 8, 1'b0, 4, s, e2);
        if (push) begin
            q0.push_back(e0);
            q1.push_back(e1);
            q2.push_back(e2);
        end
    endtask

    task automatic idle(input int n);
        stim_t s;
        s = '0;
        for (int i = 0; i < n; i++) cycle(s, 1'b1);
    endtask

    task automatic chk(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %0h, expected %0h", nm, k, $time, act, exp);
        end
    endtask

    task automatic compare(input int k, input exp_t a, input exp_t e);
        chk("hazard", k, 32'(a.hazard), 32'(e.hazard));
        chk("freeze", k, 32'(a.freeze), 32'(e.freeze));
        chk("fwd_mux0_ex", k, 32'(a.m0), 32'(e.m0));
        chk("fwd_mux1_ex", k, 32'(a.m1), 32'(e.m1));
        chk("forward_id_rs", k, 32'(a.fr), 32'(e.fr));
        chk("forward_id_rt", k, 32'(a.ft), 32'(e.ft));
        chk("stall_count", k, a.sc, e.sc);
        chk("forward_count", k, a.fc, e.fc);
    endtask

    // Monitor: outputs are presented every cycle; compare at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                compare(0, {hz[0], fz[0], m0[0], m1[0], fr[0], ft[0], sc0, fc0}, e);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                compare(1, {hz[1], fz[1], m0[1], m1[1], fr[1], ft[1], sc1, fc1}, e);
            end
            if (q2.size() > 0) begin
                e = q2.pop_front();
                compare(2, {hz[2], fz[2], m0[2], m1[2], fr[2], ft[2], {28'd0, sc2},
                            {28'd0, fc2}}, e);
            end
        end
    end

    initial begin
        stim_t s;
        for (int k = 0; k < 3; k++) begin
            frz_left[k] = 0;
            in_rel[k]   = 0;
            stall_c[k]  = 0;
            fwd_c[k]    = 0;
        end
        s = '0;
        s.reset = 1;
        cycle(s, 1'b0);
        cycle(s, 1'b1);

        // Load-use, then the same with r0 as source
        s = '0; s.ex_reg_write = 1; s.ex_mem_read = 1; s.ex_dest = 8;
        s.id_rs = 8; s.id_use_rs = 1;
        cycle(s, 1'b1);
        s.id_rs = 0;
        cycle(s, 1'b1);

        // EX forwarding priority, then MEM holds a load
        s = '0; s.mem_reg_write = 1; s.mem_dest = 5; s.wb_reg_write = 1; s.wb_dest = 5;
        s.ex_rs = 5; s.ex_rt = 5;
        cycle(s, 1'b1);
        cycle(s, 1'b1);
        s.mem_mem_read = 1;
        cycle(s, 1'b1);
        idle(9);

        // Branch hazards and ID forwarding
        s = '0; s.id_branch = 1; s.id_rs = 3; s.id_use_rs = 1;
        s.ex_reg_write = 1; s.ex_dest = 3;
        cycle(s, 1'b1);
        s.ex_reg_write = 0; s.mem_reg_write = 1; s.mem_mem_read = 1; s.mem_dest = 3;
        cycle(s, 1'b1);
        idle(9);
        s.mem_mem_read = 0;
        cycle(s, 1'b1);

        // Memory pulse with a simultaneous load-use held across the freeze
        s = '0; s.ex_reg_write = 1; s.ex_mem_read = 1; s.ex_dest = 9;
        s.id_rt = 9; s.id_use_rt = 1; s.mem_mem_read = 1;
        cycle(s, 1'b1);
        s.mem_mem_read = 0;
        for (int i = 0; i < 8; i++) cycle(s, 1'b1);

        // Stall-only behaviour: ALU in MEM, then WB only
        s = '0; s.mem_reg_write = 1; s.mem_dest = 7; s.id_rt = 7; s.id_use_rt = 1;
        s.ex_rs = 7; s.ex_rt = 7;
        cycle(s, 1'b1);
        s.mem_reg_write = 0; s.wb_reg_write = 1; s.wb_dest = 7;
        cycle(s, 1'b1);

        // Reset in the middle of a long freeze, then a full restart
        idle(2);
        s = '0; s.mem_mem_write = 1;
        cycle(s, 1'b1);
        idle(1);
        s = '0; s.reset = 1;
        cycle(s, 1'b1);
        idle(1);
        s = '0; s.mem_mem_read = 1;
        cycle(s, 1'b1);
        idle(9);

        // Randomized traffic over a small register set
        for (int i = 0; i < 800; i++) begin
            s.reset         = ($urandom_range(0, 99) == 0);
            s.id_rs         = 5'($urandom_range(0, 3));
            s.id_rt         = 5'($urandom_range(0, 3));
            s.id_use_rs     = 1'($urandom);
            s.id_use_rt     = 1'($urandom);
            s.id_branch     = 1'($urandom);
            s.ex_rs         = 5'($urandom_range(0, 3));
            s.ex_rt         = 5'($urandom_range(0, 3));
            s.ex_reg_write  = 1'($urandom);
            s.ex_mem_read   = 1'($urandom);
            s.ex_dest       = 5'($urandom_range(0, 3));
            s.mem_reg_write = 1'($urandom);
            s.mem_mem_read  = ($urandom_range(0, 9) == 0);
            s.mem_mem_write = ($urandom_range(0, 14) == 0);
            s.mem_dest      = 5'($urandom_range(0, 3));
            s.wb_reg_write  = 1'($urandom);
            s.wb_dest       = 5'($urandom_range(0, 3));
            cycle(s, 1'b1);
        end

        @(negedge clk);
        @(negedge clk);
        n_asserts++;
        if (q0.size() + q1.size() + q2.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0",
                     q0.size() + q1.size() + q2.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised successor to the pipeline's load-use hazard detector.
- Combines, in one unit for the 5-stage MIPS pipeline:
  - RAW hazard detection for ID-stage branch resolution and load-use.
  - EX-stage forwarding selects.
  - ID-stage branch-compare forwarding.
  - Multi-cycle data-memory freeze FSM.
  - Saturating stall and forward statistics counters.
- Sits beside the pipeline registers. Drives the IF/ID/ID-EX stall, the global freeze, and the forwarding muxes in execute and decode.

Parameters:
REG_BITS, 5, register address width; register 0 is hardwired zero and never causes hazards or forwarding.
MEM_LATENCY, 1, cycles a load/store occupies MEM (1..16); 1 means no freeze.
FORWARDING, 1, 1 = full forwarding; 0 = stall-only mode (forward selects forced 0).
CNT_WIDTH, 32, width of statistics counters.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
idRs, idRt  in  REG_BITS  source registers of instruction in ID
idUseRs, idUseRt  in  1  ID instruction actually reads rs / rt
idBranch  in  1  ID instruction is a branch compared in ID
exRs, exRt  in  REG_BITS  source registers of instruction in EX
exRegWrite, exMemRead  in  1  EX control bits
exDest  in  REG_BITS  EX destination (post regDst mux)
memRegWrite, memMemRead, memMemWrite  in  1  MEM control bits
memDest  in  REG_BITS  MEM destination
wbRegWrite  in  1  WB control bit
wbDest  in  REG_BITS  WB destination
hazard  out  1  hold PC and IF/ID, insert bubble into ID/EX
freeze  out  1  hold every pipeline register (memory busy)
forwardingMux0Ex, forwardingMux1Ex  out  2  EX operand select: 0 regfile, 1 WB write data, 2 MEM ALU result
forwardIdRs, forwardIdRt  out  1  ID branch comparator takes MEM ALU result
stallCount, forwardCount  out  CNT_WIDTH  statistics

Behaviour:
- Reset (sync, reset high at clk edge):
  - FSM to IDLE; wait counter and both statistics counters to 0.
  - While reset is high, hazard, freeze, forwardIdRs and forwardIdRt are forced 0.
- Source valid:
  - srcRs = idUseRs & idRs!=0; likewise for rt.
  - A source hits a stage when that stage's regWrite=1 and its dest equals the source.
- Hazard, FORWARDING=1: hazard=1 if any valid ID source:
  - hits EX with exMemRead=1 (load-use, 1 bubble); or
  - hits EX while idBranch=1 (ALU or load); or
  - hits MEM with memMemRead=1 while idBranch=1.
- Hazard, FORWARDING=0: hazard=1 if any valid ID source hits EX or MEM.
  - The WB write is visible to ID (write-first regfile), so WB never stalls.
- EX forwarding (FORWARDING=1, per operand exRs→Mux0, exRt→Mux1, operand !=0):
  - 2 if memRegWrite & !memMemRead & memDest==operand;
  - else 1 if wbRegWrite & wbDest==operand;
  - else 0.
  - MEM priority over WB (newest value).
- ID forwarding: forwardIdRs = FORWARDING & idBranch & memRegWrite & !memMemRead & memDest==idRs & idRs!=0; likewise forwardIdRt.
- Freeze FSM, states IDLE / WAIT with a 4-bit counter cnt. memAccess = memMemRead | memMemWrite.
  - IDLE & memAccess & MEM_LATENCY>1: freeze=1 (combinational); next WAIT, cnt=MEM_LATENCY-2.
  - WAIT & cnt!=0: freeze=1, cnt decrements.
  - WAIT & cnt==0: freeze=0, next IDLE. The held op leaves MEM this cycle and is not re-triggered.
  - Net effect: each access freezes exactly MEM_LATENCY-1 cycles. MEM_LATENCY=1 never leaves IDLE.
  - Back-to-back accesses: next access is seen in IDLE on the following cycle and triggers a new freeze.
- Priority: freeze=1 forces hazard=0 (stall re-evaluated after release). Forwarding selects remain valid during freeze.
- Counters (saturating at all-ones, registered, update every non-reset edge):
  - stallCount +1 when hazard|freeze.
  - forwardCount +1 when !freeze and (Mux0!=0 or Mux1!=0 or forwardIdRs or forwardIdRt); one increment per cycle regardless of how many selects are active.
- Reset mid-WAIT: FSM returns to IDLE on that edge; freeze low while reset is high and after.

Test Plan:
- Load-use: exMemRead=1, exRegWrite=1, exDest=8, idRs=8, idUseRs=1 → hazard=1 for that cycle, stallCount 0→1. Repeat with idRs=0 → hazard=0.
- EX forwarding priority: memRegWrite=1, memDest=5, wbRegWrite=1, wbDest=5, exRs=5, exRt=5 → Mux0=2, Mux1=2. Set memMemRead=1 → both 1. forwardCount increments by 1 per cycle.
- Branch hazards: idBranch=1, idRs=3; ALU in EX dest 3 → hazard=1. Load in MEM dest 3 → hazard=1. ALU in MEM dest 3 → hazard=0, forwardIdRs=1.
- MEM_LATENCY=4: memMemRead pulse in IDLE → freeze high exactly 3 cycles then low 1 cycle, stallCount +3. Simultaneous load-use → hazard held 0 during freeze.
- FORWARDING=0: ALU in MEM dest 7, idRt=7, idUseRt=1 → hazard=1. All forward selects 0. WB dest 7 only → hazard=0.
- Reset in WAIT (MEM_LATENCY=8, reset asserted after 2 freeze cycles) → freeze 0 from the reset cycle, counters 0, next access restarts a full 7-cycle freeze.
